// File: rtl/axi4_read_sched_if.sv
// axi4_read_sched_if: requester command/completion and read-controller signals shared by the scheduler
interface axi4_read_sched_if #(
  parameter int NUM_REQ             = 4,
  parameter int AXI_ADDR_WIDTH      = 32,
  parameter int AXI_DATA_WIDTH      = 32,
  parameter int TRAN_BYTE_NUM_WIDTH = 16,
  parameter int SRAM_ADDR_WIDTH     = 32
);
  localparam int STRB = AXI_DATA_WIDTH / 8;
  logic [NUM_REQ-1:0]                     req_valid_i;
  logic [NUM_REQ-1:0]                     req_ready_o;
  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]      req_addr_i;
  logic [NUM_REQ*TRAN_BYTE_NUM_WIDTH-1:0] req_byte_num_i;
  logic [NUM_REQ-1:0]                     req_done_o;
  logic [NUM_REQ-1:0]                     req_error_o;
  logic [NUM_REQ*STRB-1:0]                sram_we_o;
  logic [SRAM_ADDR_WIDTH-1:0]             sram_addr_o;
  logic [AXI_DATA_WIDTH-1:0]              sram_data_o;
  logic                                   sched_busy_o;
  logic                                   rd_start_o;
  logic [AXI_ADDR_WIDTH-1:0]              rd_base_addr_o;
  logic [TRAN_BYTE_NUM_WIDTH-1:0]         rd_byte_num_o;
  logic                                   rd_busy_i;
  logic [SRAM_ADDR_WIDTH-1:0]             rd_sram_addr_i;
  logic [STRB-1:0]                        rd_sram_data_valid_i;
  logic [AXI_DATA_WIDTH-1:0]              rd_sram_data_i;
  logic                                   rd_error_i;
  // scheduler side
  modport master (
    input  req_valid_i, req_addr_i, req_byte_num_i, rd_busy_i, rd_sram_addr_i,
           rd_sram_data_valid_i, rd_sram_data_i, rd_error_i,
    output req_ready_o, req_done_o, req_error_o, sram_we_o, sram_addr_o, sram_data_o,
           sched_busy_o, rd_start_o, rd_base_addr_o, rd_byte_num_o
  );
  // requesters and read controller side
  modport slave (
    output req_valid_i, req_addr_i, req_byte_num_i, rd_busy_i, rd_sram_addr_i,
           rd_sram_data_valid_i, rd_sram_data_i, rd_error_i,
    input  req_ready_o, req_done_o, req_error_o, sram_we_o, sram_addr_o, sram_data_o,
           sched_busy_o, rd_start_o, rd_base_addr_o, rd_byte_num_o
  );
endinterface

// File: rtl/axi4_read_sched.sv
// axi4_read_sched: round-robin sharing of one AXI4 burst-read controller among NUM_REQ load requesters
module axi4_read_sched #(
  parameter int NUM_REQ             = 4,
  parameter int AXI_ADDR_WIDTH      = 32,
  parameter int AXI_DATA_WIDTH      = 32,
  parameter int TRAN_BYTE_NUM_WIDTH = 16,
  parameter int SRAM_ADDR_WIDTH     = 32
) (
  input logic clk,
  input logic rst_n,
  axi4_read_sched_if.master bus
);
  localparam int STRB = AXI_DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_DONE} state_t;
  state_t                         r_state;
  logic [IW-1:0]                  r_gnt_idx;
  logic [IW-1:0]                  r_rr_ptr;
  logic [AXI_ADDR_WIDTH-1:0]      r_addr;
  logic [TRAN_BYTE_NUM_WIDTH-1:0] r_bytes;
  logic                           r_rd_start;
  logic [NUM_REQ-1:0]             r_done;
  logic                           r_zero;
  logic [IW:0]                    w_sum;
  logic [IW-1:0]                  w_k;
  logic [IW-1:0]                  w_gnt_idx;
  logic [IW-1:0]                  w_next_ptr;
  logic                           w_found;
  logic [NUM_REQ-1:0]             w_pick;
  logic [NUM_REQ-1:0]             w_gnt_oh;
  logic [AXI_ADDR_WIDTH-1:0]      w_addr;
  logic [TRAN_BYTE_NUM_WIDTH-1:0] w_bytes;
  logic                           w_steer;
  // first valid requester at or above r_rr_ptr, wrapping past the top index
  always_comb begin
    w_sum = '0;
    w_k = '0;
    w_gnt_idx = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(i);
      w_k = (w_sum >= NR) ? IW'(w_sum - NR) : w_sum[IW-1:0];
      if (!w_found && bus.req_valid_i[w_k]) begin
        w_found = 1'b1;
        w_gnt_idx = w_k;
      end
    end
  end
  assign w_pick     = w_found ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign w_gnt_oh   = NUM_REQ'(1) << r_gnt_idx;
  assign w_addr     = bus.req_addr_i[w_gnt_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
  assign w_bytes    = bus.req_byte_num_i[w_gnt_idx*TRAN_BYTE_NUM_WIDTH +: TRAN_BYTE_NUM_WIDTH];
  assign w_next_ptr = (w_gnt_idx == IW'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_steer    = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE) || (r_state == S_DONE);
  assign bus.req_ready_o    = (r_state == S_IDLE) ? w_pick : '0;
  assign bus.req_done_o     = r_done;
  assign bus.req_error_o    = (bus.rd_error_i && !r_zero) ? r_done : '0;
  assign bus.sched_busy_o   = r_state != S_IDLE;
  assign bus.rd_start_o     = r_rd_start;
  assign bus.rd_base_addr_o = r_addr;
  assign bus.rd_byte_num_o  = r_bytes;
  assign bus.sram_addr_o    = bus.rd_sram_addr_i;
  assign bus.sram_data_o    = bus.rd_sram_data_i;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_we
    assign bus.sram_we_o[g*STRB +: STRB] = (w_steer && r_gnt_idx == IW'(g)) ? bus.rd_sram_data_valid_i : '0;
  end
  // command FSM: grant, one-cycle start, wait for the busy pulse, then one-cycle done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt_idx  <= '0;
      r_rr_ptr   <= '0;
      r_addr     <= '0;
      r_bytes    <= '0;
      r_rd_start <= 1'b0;
      r_done     <= '0;
      r_zero     <= 1'b0;
    end else begin
      r_rd_start <= 1'b0;
      r_done     <= '0;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_gnt_idx  <= w_gnt_idx;
          r_addr     <= w_addr;
          r_bytes    <= w_bytes;
          r_rr_ptr   <= w_next_ptr;
          r_zero     <= w_bytes == '0;
          r_rd_start <= w_bytes != '0;
          r_done     <= (w_bytes == '0) ? w_pick : '0;
          r_state    <= (w_bytes == '0) ? S_DONE : S_START;
        end
        S_START: r_state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (bus.rd_busy_i) r_state <= S_WAIT_DONE;
        S_WAIT_DONE: if (!bus.rd_busy_i) begin
          r_state <= S_DONE;
          r_done  <= w_gnt_oh;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_read_sched.sv
// tb_axi4_read_sched: directed checks of grant order, start/done timing, steering, errors and reset
module tb_axi4_read_sched;
  localparam int NR = 4, AW = 32, DW = 32, BW = 16, SW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [NR-1:0] vmask;
  always #5 clk = ~clk;
  axi4_read_sched_if #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .TRAN_BYTE_NUM_WIDTH(BW), .SRAM_ADDR_WIDTH(SW)) bus_if ();
  axi4_read_sched #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .TRAN_BYTE_NUM_WIDTH(BW), .SRAM_ADDR_WIDTH(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_cmd(input int k, input logic [31:0] addr, input logic [15:0] nb, input int nbeats,
                         input logic [3:0] s0, input logic [3:0] sm, input logic [3:0] sl, input logic err);
    logic [3:0] oh;
    logic [3:0] s;
    oh = 4'(1 << k);
    bus_if.req_addr_i[k*AW +: AW] = addr;
    bus_if.req_byte_num_i[k*BW +: BW] = nb;
    bus_if.req_valid_i = vmask;
    #1;
    chk("grant_ready", 64'(bus_if.req_ready_o), 64'(oh));
    step();
    vmask[k] = 1'b0;
    bus_if.req_valid_i = vmask;
    #1;
    chk("start", 64'(bus_if.rd_start_o), 64'd1);
    chk("base_addr", 64'(bus_if.rd_base_addr_o), 64'(addr));
    chk("byte_num", 64'(bus_if.rd_byte_num_o), 64'(nb));
    chk("ready_busy", 64'(bus_if.req_ready_o), 64'd0);
    chk("we_start", 64'(bus_if.sram_we_o), 64'd0);
    bus_if.rd_error_i = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      step();
      s = (b == 0) ? s0 : (b == nbeats - 1) ? sl : sm;
      bus_if.rd_busy_i = (b != nbeats - 1);
      bus_if.rd_sram_data_valid_i = s;
      if (b == nbeats - 1) bus_if.rd_error_i = err;
      #1;
      chk("we_beat", 64'(bus_if.sram_we_o), 64'(16'(s) << (4 * k)));
      chk("start_once", 64'(bus_if.rd_start_o), 64'd0);
      chk("done_early", 64'(bus_if.req_done_o), 64'd0);
    end
    step();
    bus_if.rd_busy_i = 1'b0;
    bus_if.rd_sram_data_valid_i = 4'h0;
    #1;
    chk("done", 64'(bus_if.req_done_o), 64'(oh));
    chk("error", 64'(bus_if.req_error_o), err ? 64'(oh) : 64'd0);
    step();
    chk("done_pulse", 64'(bus_if.req_done_o), 64'd0);
    chk("idle", 64'(bus_if.sched_busy_o), 64'd0);
  endtask
  initial begin
    vmask = '0;
    bus_if.req_valid_i = '0;
    bus_if.req_addr_i = '0;
    bus_if.req_byte_num_i = '0;
    bus_if.rd_busy_i = 1'b0;
    bus_if.rd_sram_addr_i = 32'hA5A5_0010;
    bus_if.rd_sram_data_valid_i = 4'h0;
    bus_if.rd_sram_data_i = 32'hDEAD_BEEF;
    bus_if.rd_error_i = 1'b0;
    #1;
    chk("rst_ready", 64'(bus_if.req_ready_o), 64'd0);
    chk("rst_done", 64'(bus_if.req_done_o), 64'd0);
    chk("rst_error", 64'(bus_if.req_error_o), 64'd0);
    chk("rst_we", 64'(bus_if.sram_we_o), 64'd0);
    chk("rst_busy", 64'(bus_if.sched_busy_o), 64'd0);
    chk("rst_start", 64'(bus_if.rd_start_o), 64'd0);
    chk("rst_base", 64'(bus_if.rd_base_addr_o), 64'd0);
    chk("rst_num", 64'(bus_if.rd_byte_num_o), 64'd0);
    chk("pass_addr", 64'(bus_if.sram_addr_o), 64'hA5A5_0010);
    chk("pass_data", 64'(bus_if.sram_data_o), 64'hDEAD_BEEF);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    vmask = 4'b0001;
    run_cmd(0, 32'h1000, 16'd64, 16, 4'hF, 4'hF, 4'hF, 1'b0);
    vmask = 4'b0010;
    run_cmd(1, 32'h1003, 16'd6, 3, 4'h8, 4'hF, 4'h1, 1'b0);
    vmask = 4'b1111;
    run_cmd(2, 32'h2000, 16'd16, 4, 4'hF, 4'hF, 4'hF, 1'b0);
    run_cmd(3, 32'h3000, 16'd16, 4, 4'hF, 4'hF, 4'hF, 1'b0);
    run_cmd(0, 32'h4000, 16'd16, 4, 4'hF, 4'hF, 4'hF, 1'b0);
    run_cmd(1, 32'h5000, 16'd16, 4, 4'hF, 4'hF, 4'hF, 1'b0);
    bus_if.req_byte_num_i[2*BW +: BW] = 16'd0;
    bus_if.req_valid_i = 4'b0100;
    bus_if.rd_sram_data_valid_i = 4'hF;
    #1;
    chk("zl_ready", 64'(bus_if.req_ready_o), 64'h4);
    chk("zl_we_idle", 64'(bus_if.sram_we_o), 64'd0);
    step();
    bus_if.req_valid_i = 4'b0000;
    bus_if.rd_sram_data_valid_i = 4'h0;
    #1;
    chk("zl_done", 64'(bus_if.req_done_o), 64'h4);
    chk("zl_error", 64'(bus_if.req_error_o), 64'd0);
    chk("zl_start", 64'(bus_if.rd_start_o), 64'd0);
    chk("zl_we", 64'(bus_if.sram_we_o), 64'd0);
    step();
    chk("zl_pulse", 64'(bus_if.req_done_o), 64'd0);
    chk("zl_start2", 64'(bus_if.rd_start_o), 64'd0);
    chk("zl_idle", 64'(bus_if.sched_busy_o), 64'd0);
    vmask = 4'b1000;
    run_cmd(3, 32'h6000, 16'd8, 2, 4'hF, 4'hF, 4'hF, 1'b1);
    vmask = 4'b0001;
    run_cmd(0, 32'h7000, 16'd8, 2, 4'hF, 4'hF, 4'hF, 1'b0);
    bus_if.req_addr_i[1*AW +: AW] = 32'h8000;
    bus_if.req_byte_num_i[1*BW +: BW] = 16'd32;
    bus_if.req_valid_i = 4'b0010;
    step();
    bus_if.req_valid_i = 4'b0000;
    #1;
    chk("mr_start", 64'(bus_if.rd_start_o), 64'd1);
    step();
    bus_if.rd_busy_i = 1'b1;
    bus_if.rd_sram_data_valid_i = 4'hF;
    step();
    #1;
    chk("mr_we", 64'(bus_if.sram_we_o), 64'h00F0);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 64'(bus_if.sched_busy_o), 64'd0);
    chk("mr_we0", 64'(bus_if.sram_we_o), 64'd0);
    chk("mr_base", 64'(bus_if.rd_base_addr_o), 64'd0);
    chk("mr_num", 64'(bus_if.rd_byte_num_o), 64'd0);
    chk("mr_done", 64'(bus_if.req_done_o), 64'd0);
    chk("mr_ready", 64'(bus_if.req_ready_o), 64'd0);
    bus_if.rd_busy_i = 1'b0;
    bus_if.rd_sram_data_valid_i = 4'h0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    vmask = 4'b1111;
    run_cmd(0, 32'h9000, 16'd16, 4, 4'hF, 4'hF, 4'hF, 1'b0);
    run_cmd(1, 32'hA000, 16'd16, 4, 4'hF, 4'hF, 4'hF, 1'b0);
    run_cmd(2, 32'hB000, 16'd16, 4, 4'hF, 4'hF, 4'hF, 1'b0);
    run_cmd(3, 32'hC000, 16'd16, 4, 4'hF, 4'hF, 4'hF, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
